// File: rtl/dcache_tag_way_p_if.sv
// Bus interface for one tag way of the L1 data cache: lookup, refill
// allocation, victim export, multi-port invalidate and init status.
// The cache controller side uses the master modport, the tag way uses slave.
interface dcache_tag_way_p_if #(
    parameter int SET_W    = 6,
    parameter int TAG_W    = 30,
    parameter int WAYS_LOG = 3,
    parameter int INV_N    = 6
);
    logic                    rd_en;
    logic [SET_W-1:0]        rd_set;
    logic [TAG_W-1:0]        rd_tag;
    logic                    hit;
    logic                    hit_excl;
    logic                    err;
    logic                    recent_out;
    logic                    alloc_en;
    logic [2*WAYS_LOG-1:0]   alloc_rand;
    logic                    alloc_recent;
    logic                    alloc_excl;
    logic                    victim_valid;
    logic [TAG_W+SET_W-1:0]  victim_addr;
    logic [INV_N-1:0]        inv_en;
    logic [INV_N*SET_W-1:0]  inv_set;
    logic                    busy;

    modport master (
        output rd_en, rd_set, rd_tag, alloc_en, alloc_rand, alloc_recent,
               alloc_excl, inv_en, inv_set,
        input  hit, hit_excl, err, recent_out, victim_valid, victim_addr, busy
    );

    modport slave (
        input  rd_en, rd_set, rd_tag, alloc_en, alloc_rand, alloc_recent,
               alloc_excl, inv_en, inv_set,
        output hit, hit_excl, err, recent_out, victim_valid, victim_addr, busy
    );
endinterface

// File: rtl/dcache_tag_way_p.sv
// One way of the L1 data-cache tag array. Holds tag/valid/exclusive/recent
// (and optionally parity) per set, does a one-cycle lookup, allocates on a
// random-way refill, exports the victim and clears itself after reset.
// Optional feature macro: DCACHE_TAG_PARITY_EN (stored even parity + check).
module dcache_tag_way_p #(
    parameter int SET_W    = 6,
    parameter int TAG_W    = 30,
    parameter int WAYS_LOG = 3,
    parameter int INDEX    = 0,
    parameter int INV_N    = 6
) (
    input  logic               clk,
    input  logic               rst,
    dcache_tag_way_p_if.slave  bus
);
    localparam int SETS = 2**SET_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [SET_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_rd_en;
    logic [SET_W-1:0]    r_rd_set;
    logic [TAG_W-1:0]    r_rd_tag;

    logic [TAG_W-1:0]    r_tag [SETS];
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_excl;
    logic [SETS-1:0]     r_recent;

    logic [TAG_W-1:0]    w_rd_tag;
    logic                w_rd_valid;
    logic                w_rd_excl;
    logic                w_rd_recent;
    logic                w_par_ok;
    logic                w_hit;
    logic                w_alloc_sel;
    logic [WAYS_LOG-1:0] w_rand_hi;
    logic [WAYS_LOG-1:0] w_rand_lo;
    logic [SETS-1:0]     w_inv_dec [INV_N];
    logic [SETS-1:0]     w_inv_hit;
    logic [TAG_W-1:0]    w_new_tag;
    logic                w_new_valid;
    logic                w_new_excl;
    logic                w_new_recent;

    // Entry of the latched lookup set; array read is combinational on the
    // registered set, so anything written at the latching edge is seen.
    assign w_rd_tag    = r_tag[r_rd_set];
    assign w_rd_valid  = r_valid[r_rd_set];
    assign w_rd_excl   = r_excl[r_rd_set];
    assign w_rd_recent = r_recent[r_rd_set];

`ifdef DCACHE_TAG_PARITY_EN
    logic [SETS-1:0]     r_par;
    logic                w_rd_par;
    logic                w_new_par;
    assign w_rd_par = r_par[r_rd_set];
    assign w_par_ok = ~^{w_rd_tag, w_rd_valid, w_rd_recent, w_rd_excl, w_rd_par};
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rand_hi   = bus.alloc_rand[2*WAYS_LOG-1:WAYS_LOG];
    assign w_rand_lo   = bus.alloc_rand[WAYS_LOG-1:0];
    assign w_hit       = r_rd_en & w_rd_valid & (w_rd_tag == r_rd_tag) & w_par_ok;
    assign w_alloc_sel = r_rd_en & bus.alloc_en &
                         ((bus.alloc_recent ? w_rand_hi : w_rand_lo) == WAYS_LOG'(INDEX));

    assign bus.hit          = w_hit;
    assign bus.hit_excl     = w_hit & w_rd_excl;
    assign bus.err          = r_rd_en & ~w_par_ok;
    assign bus.recent_out   = r_rd_en & w_rd_recent & (w_rand_lo == WAYS_LOG'(INDEX));
    assign bus.victim_valid = w_alloc_sel & w_rd_valid;
    assign bus.victim_addr  = w_alloc_sel ? {w_rd_tag, r_rd_set} : '0;
    assign bus.busy         = r_busy;

    // One-hot set decode per invalidate port.
    genvar gi;
    generate
        for (gi = 0; gi < INV_N; gi++) begin : g_inv
            assign w_inv_dec[gi] = bus.inv_en[gi] ?
                                   (SETS'(1) << bus.inv_set[gi*SET_W +: SET_W]) : '0;
        end
    endgenerate

    // Merge all invalidate ports into one per-set clear mask.
    always_comb begin
        w_inv_hit = '0;
        for (int p = 0; p < INV_N; p++) begin
            w_inv_hit = w_inv_hit | w_inv_dec[p];
        end
    end

    // Next contents of the looked-up set: recent update, overridden by
    // allocation, with invalidate winning on the valid bit. Parity is
    // adjusted incrementally on the recent/valid-only paths so a corrupted
    // entry keeps reporting its error instead of being silently healed.
    always_comb begin
        w_new_tag    = w_rd_tag;
        w_new_valid  = w_rd_valid;
        w_new_excl   = w_rd_excl;
        w_new_recent = w_hit;
`ifdef DCACHE_TAG_PARITY_EN
        w_new_par    = w_rd_par ^ w_rd_recent ^ w_hit;
`endif
        if (w_alloc_sel) begin
            w_new_tag    = r_rd_tag;
            w_new_valid  = 1'b1;
            w_new_excl   = bus.alloc_excl;
            w_new_recent = 1'b0;
`ifdef DCACHE_TAG_PARITY_EN
            w_new_par    = ^{r_rd_tag, 1'b1, 1'b0, bus.alloc_excl};
`endif
        end
        if (w_inv_hit[r_rd_set]) begin
`ifdef DCACHE_TAG_PARITY_EN
            w_new_par    = w_new_par ^ w_new_valid;
`endif
            w_new_valid  = 1'b0;
        end
    end

    // Control FSM: init sweep counter, busy flag and lookup latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_rd_en  <= 1'b0;
            r_rd_set <= '0;
            r_rd_tag <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_en <= 1'b0;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == SET_W'(SETS - 1)) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_rd_en <= bus.rd_en;
                    if (bus.rd_en) begin
                        r_rd_set <= bus.rd_set;
                        r_rd_tag <= bus.rd_tag;
                    end
                end
            endcase
        end
    end

    // Tag storage: sweep clears one set per cycle, otherwise the looked-up
    // set takes its merged update and other sets only see invalidates.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_tag[r_cnt]    <= '0;
            r_valid[r_cnt]  <= 1'b0;
            r_excl[r_cnt]   <= 1'b0;
            r_recent[r_cnt] <= 1'b0;
`ifdef DCACHE_TAG_PARITY_EN
            r_par[r_cnt]    <= 1'b0;
`endif
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if (r_rd_en && (r_rd_set == SET_W'(s))) begin
                    r_tag[s]    <= w_new_tag;
                    r_valid[s]  <= w_new_valid;
                    r_excl[s]   <= w_new_excl;
                    r_recent[s] <= w_new_recent;
`ifdef DCACHE_TAG_PARITY_EN
                    r_par[s]    <= w_new_par;
`endif
                end else if (w_inv_hit[s]) begin
                    r_valid[s]  <= 1'b0;
`ifdef DCACHE_TAG_PARITY_EN
                    r_par[s]    <= r_par[s] ^ r_valid[s];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_tag_way_p.sv
// Scoreboard bench for dcache_tag_way_p (default parameters, INDEX=0).
// Stimulus pushes the hand-computed response of each lookup; a monitor pops
// and compares on the cycle the way presents its lookup result.
module tb_dcache_tag_way_p;
`ifdef DCACHE_TAG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_tag_way_p_if #(.SET_W(6), .TAG_W(30), .WAYS_LOG(3), .INV_N(6)) bus();

    dcache_tag_way_p #(.SET_W(6), .TAG_W(30), .WAYS_LOG(3), .INDEX(0), .INV_N(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  set;
        logic [29:0] tag;
        logic        hit;
        logic        excl;
        logic        err;
        logic        rec;
        logic        vv;
        logic [35:0] va;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;
    logic look_flag = 1'b0;
    logic mon_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A lookup accepted at this edge is answered during the following cycle.
    always @(posedge clk) look_flag <= bus.rd_en;

    // Monitor: compare response cycles against the scoreboard; otherwise hit
    // and victim outputs must stay quiet.
    always @(negedge clk) begin
        exp_t e;
        if (look_flag) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                n_txn++;
                $display("txn %0d set=%0d tag=%h hit=%b excl=%b err=%b rec=%b vv=%b va=%h",
                         n_txn, e.set, e.tag, bus.hit, bus.hit_excl, bus.err,
                         bus.recent_out, bus.victim_valid, bus.victim_addr);
                chk("hit",          bus.hit,          e.hit);
                chk("hit_excl",     bus.hit_excl,     e.excl);
                chk("err",          bus.err,          e.err);
                chk("recent_out",   bus.recent_out,   e.rec);
                chk("victim_valid", bus.victim_valid, e.vv);
                chk("victim_addr",  bus.victim_addr,  e.va);
            end
        end else if (mon_on) begin
            chk("idle_hit",    bus.hit,          1'b0);
            chk("idle_victim", bus.victim_valid, 1'b0);
        end
    end

    // One lookup: rd_en for a cycle, then the alloc/invalidate inputs during
    // the response cycle. Expected response goes to the scoreboard.
    task automatic look(input logic [5:0] s, input logic [29:0] t, input logic [5:0] rnd,
                        input logic a_en, input logic a_rec, input logic a_excl,
                        input logic [5:0] i_en, input logic [35:0] i_set,
                        input logic e_hit, input logic e_excl, input logic e_err,
                        input logic e_rec, input logic e_vv, input logic [35:0] e_va);
        exp_t e;
        e.set = s; e.tag = t; e.hit = e_hit; e.excl = e_excl; e.err = e_err;
        e.rec = e_rec; e.vv = e_vv; e.va = e_va;
        sb_q.push_back(e);
        bus.rd_en  = 1'b1;
        bus.rd_set = s;
        bus.rd_tag = t;
        @(posedge clk); #1;
        bus.rd_en        = 1'b0;
        bus.alloc_en     = a_en;
        bus.alloc_rand   = rnd;
        bus.alloc_recent = a_rec;
        bus.alloc_excl   = a_excl;
        bus.inv_en       = i_en;
        bus.inv_set      = i_set;
        @(posedge clk); #1;
        bus.alloc_en = 1'b0;
        bus.inv_en   = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        bus.rd_en = 1'b0; bus.rd_set = '0; bus.rd_tag = '0;
        bus.alloc_en = 1'b0; bus.alloc_rand = '0; bus.alloc_recent = 1'b0;
        bus.alloc_excl = 1'b0; bus.inv_en = '0; bus.inv_set = '0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk("rst_busy",     bus.busy,         1'b1);
        chk("rst_hit",      bus.hit,          1'b0);
        chk("rst_excl",     bus.hit_excl,     1'b0);
        chk("rst_err",      bus.err,          1'b0);
        chk("rst_recent",   bus.recent_out,   1'b0);
        chk("rst_vv",       bus.victim_valid, 1'b0);
        chk("rst_va",       bus.victim_addr,  36'd0);
        mon_on = 1'b1;

        // Test 1: 64-cycle sweep, then every set misses (tag 0 but invalid)
        rst = 1'b0;
        count_busy(n);
        chk("sweep_cycles", n, 64);
        for (int s = 0; s < 64; s++)
            look(6'(s), 30'h0, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);

        // Test 2: allocate set 5, hit/miss, recent bit and way selection
        look(6'd5, 30'h1234, {3'd3, 3'd0}, 1, 0, 1, 6'd0, 36'd0, 0, 0, 0, 0, 0, {30'h0, 6'd5});
        look(6'd5, 30'h1234, {3'd3, 3'd0}, 0, 0, 0, 6'd0, 36'd0, 1, 1, 0, 0, 0, 36'd0);
        look(6'd5, 30'h1234, {3'd3, 3'd0}, 0, 0, 0, 6'd0, 36'd0, 1, 1, 0, 1, 0, 36'd0);
        look(6'd5, 30'h1234, {3'd0, 3'd7}, 1, 0, 0, 6'd0, 36'd0, 1, 1, 0, 0, 0, 36'd0);
        look(6'd5, 30'h1235, {3'd3, 3'd0}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 1, 0, 36'd0);
        look(6'd5, 30'h1235, {3'd2, 3'd0}, 1, 1, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);

        // Test 3: re-allocate set 5 through rand_hi, victim is the old line
        look(6'd5, 30'h2222, {3'd0, 3'd5}, 1, 1, 0, 6'd0, 36'd0, 0, 0, 0, 0, 1, {30'h1234, 6'd5});
        look(6'd5, 30'h1234, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);
        look(6'd5, 30'h2222, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 1, 0, 0, 0, 0, 36'd0);

        // Test 4: two invalidate ports on set 5 beat a same-cycle allocation
        look(6'd5, 30'h3333, {3'd1, 3'd0}, 1, 0, 1, 6'b100001, {6'd5, 24'd0, 6'd5},
             0, 0, 0, 1, 1, {30'h2222, 6'd5});
        look(6'd5, 30'h3333, {3'd1, 3'd0}, 1, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, {30'h3333, 6'd5});
        look(6'd5, 30'h3333, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 1, 0, 0, 0, 0, 36'd0);
        look(6'd9, 30'h99,   {3'd1, 3'd0}, 1, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, {30'h0, 6'd9});
        look(6'd9, 30'h99,   {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 1, 0, 0, 0, 0, 36'd0);
        look(6'd1, 30'h0,    {3'd1, 3'd1}, 0, 0, 0, 6'b001000, (36'd9 << 18), 0, 0, 0, 0, 0, 36'd0);
        look(6'd9, 30'h99,   {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);

        // Test 5: corrupt a stored tag bit of set 7
        look(6'd7, 30'hABC, {3'd1, 3'd0}, 1, 0, 1, 6'd0, 36'd0, 0, 0, 0, 0, 0, {30'h0, 6'd7});
        look(6'd7, 30'hABC, {3'd1, 3'd0}, 0, 0, 0, 6'd0, 36'd0, 1, 1, 0, 0, 0, 36'd0);
        dut.r_tag[7] <= dut.r_tag[7] ^ 30'h1;
        #1;
        look(6'd7, 30'hABC, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, PAR, 0, 0, 36'd0);
        look(6'd7, 30'hABD, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, !PAR, !PAR, PAR, 0, 0, 36'd0);

        // Test 6: reset at sweep count 20 restarts a full 64-cycle sweep
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        chk("sweep20_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        chk("resweep_cycles", n, 64);
        look(6'd5, 30'h3333, {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);
        look(6'd7, 30'hABD,  {3'd1, 3'd1}, 0, 0, 0, 6'd0, 36'd0, 0, 0, 0, 0, 0, 36'd0);

        @(posedge clk); #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_tag_way_p.md
Name: dcache_tag_way_p

Overview:
- One way of the L1 data-cache tag array, parametrised in set count, tag width, way index and number of snoop/invalidate ports.
- Per set it holds tag, valid, exclusive, recent and parity. It performs a one-cycle lookup, allocates on a random-way refill and exposes the victim line for writeback.
- It runs a self-clearing init sweep after reset.
- N instances, one per way, sit beside the data ways in the L1 data-cache.

Parameters:
SET_W, 6, set index width; SETS = 2**SET_W
TAG_W, 30, stored tag width (physical address bits above the set index)
WAYS_LOG, 3, width of way-select fields
INDEX, 0, this instance's way number, compared against random selects
INV_N, 6, number of invalidate ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_en  in  1  lookup request
rd_set  in  SET_W  lookup set index
rd_tag  in  TAG_W  lookup tag
hit  out  1  lookup hit, valid the cycle after rd_en
hit_excl  out  1  exclusive bit of the hitting line
err  out  1  parity error on the read entry
recent_out  out  1  read entry's recent bit, qualified by rand_lo==INDEX
alloc_en  in  1  refill allocation, applies to the set latched by the last lookup
alloc_rand  in  2*WAYS_LOG  {rand_hi, rand_lo} way selects
alloc_recent  in  1  OR of all ways' recent_out; 1 selects rand_hi, else rand_lo
alloc_excl  in  1  exclusive state for the new line
victim_valid  out  1  evicted line was valid (0 when not selected)
victim_addr  out  TAG_W+SET_W  evicted line address (0 when not selected)
inv_en  in  INV_N  invalidate strobes
inv_set  in  INV_N*SET_W  invalidate set indices, packed port 0 in LSBs
busy  out  1  init sweep in progress

Behaviour:
- Reset, asynchronous: state=INIT, sweep counter=0, latched lookup registers=0, busy=1. hit, hit_excl, err, recent_out, victim_valid and victim_addr are all 0.
- FSM INIT: writes all-zero entries to set = counter each cycle and increments the counter. At counter==SETS-1 it goes to RUN the next cycle, so busy is high for exactly SETS cycles. Lookups, allocations and invalidates are ignored during INIT; hit stays 0.
- Reset asserted mid-sweep or in RUN restarts INIT from set 0.
- FSM RUN: rd_en at edge T latches set and tag. During cycle T+1, hit = stored tag==latched tag AND valid AND parity OK AND latched rd_en. The latched rd_en clears when rd_en is 0.
- Recent update at edge T+1 on a looked-up set: recent is set to 1 if hit, else 0. Tag, valid and exclusive are rewritten unchanged.
- Allocation: the way is selected when (alloc_recent ? rand_hi : rand_lo)==INDEX and alloc_en is high in the cycle after a lookup.
  - While selected, victim_addr = {old tag, set} and victim_valid = old valid.
  - At the edge the entry becomes tag=latched tag, valid=1, recent=0, exclusive=alloc_excl, with parity recomputed.
  - Allocation overrides the recent-bit update.
- Invalidate: each inv_en[i] clears valid of inv_set[i] at the next edge. Any number of ports may fire at once, including on the same set.
  - Invalidate beats an allocation or recent-bit write to the same set in the same cycle: valid ends 0.
- Storage is read-during-write write-first. A lookup of a set written at the same edge returns the new contents.
- Parity: even parity over {tag, valid, recent, exclusive}. A mismatch raises err and forces hit=0 and hit_excl=0.

Optional Feature:
- Macro DCACHE_TAG_PARITY_EN.
- Defined: the parity bit is stored and checked as described in Behaviour.
- Undefined: no parity bit is stored, err is tied to 0, and hit ignores parity.

Test Plan:
1. Reset, SET_W=6 -> busy high 64 cycles, then 0. A lookup of every set returns hit=0.
2. Allocate set 5 with tag 0x1234, excl=1, alloc_rand lo=INDEX -> a next lookup of set 5 with tag 0x1234 gives hit=1, hit_excl=1. Tag 0x1235 gives hit=0.
3. After test 2, re-allocate set 5 with tag 0x2222 -> victim_valid=1, victim_addr={0x1234,6'd5}. A following lookup of 0x1234 misses.
4. inv_en=6'b100001 with both ports on set 5, simultaneous with an alloc to set 5 -> a following lookup misses and valid=0.
5. Flip one stored tag bit via backdoor (macro defined) -> err=1 and hit=0. With the macro undefined, err=0.
6. Assert rst at sweep count 20 -> busy stays 1 and the sweep restarts at 0, taking 64 further cycles.
